// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-port register file with per-register pending-write
//            scoreboard counters. Register 0 is hard-wired to zero. Optional
//            same-cycle write-to-read forwarding on every read port.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            ra / rd         - NREAD packed read addresses / read data
//            rd_busy         - per read port: addressed register has a
//                              pending write
//            we / wa / wd    - writeback enable, address, data (retires one
//                              pending write of wa)
//            iss / iss_dst   - issue of an instruction that writes iss_dst
//            iss_ready       - issue to iss_dst can be accepted this cycle
//            flush           - clear all pending counters
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1,
  parameter int CW     = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  output logic [NREAD-1:0]       rd_busy,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic                   iss,
  input  logic [AW-1:0]          iss_dst,
  output logic                   iss_ready,
  input  logic                   flush
);

  localparam logic [CW-1:0] MAXPEND = '1;

  logic [WIDTH-1:0] regs    [NREGS];
  logic [CW-1:0]    cnt     [NREGS];
  logic [CW-1:0]    cnt_nxt [NREGS];

  logic wr_en;      // data write to a real (non-zero) register
  logic iss_acc;    // issue accepted: counter below saturation
  logic retire;     // writeback retires one pending write

  assign wr_en     = we && (wa != '0);
  assign iss_ready = (iss_dst == '0) || (cnt[iss_dst] != MAXPEND);
  assign iss_acc   = iss && (iss_dst != '0) && (cnt[iss_dst] != MAXPEND);
  // A writeback to a register with no pending write still updates data,
  // but must not underflow its counter.
  assign retire    = wr_en && (cnt[wa] != '0);

  // Next-state of every pending counter. Issue and retirement on the same
  // register cancel; flush wins over both.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_nxt[r] = cnt[r];
    end
    for (int r = 1; r < NREGS; r++) begin
      if (flush) begin
        cnt_nxt[r] = '0;
      end else if (iss_acc && (iss_dst == AW'(r)) && !(retire && (wa == AW'(r)))) begin
        cnt_nxt[r] = cnt[r] + 1'b1;
      end else if (retire && (wa == AW'(r)) && !(iss_acc && (iss_dst == AW'(r)))) begin
        cnt_nxt[r] = cnt[r] - 1'b1;
      end
    end
    cnt_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wr_en) begin
        regs[wa] <= wd;
      end
      for (int r = 0; r < NREGS; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;      // same-cycle writeback to this port's register
    logic          clears;   // that writeback retires the last pending write

    assign addr   = ra[p*AW +: AW];
    assign hit    = (BYPASS != 0) && wr_en && (wa == addr);
    assign clears = hit && retire && (cnt[addr] == CW'(1)) &&
                    !(iss_acc && (iss_dst == addr));

    assign rd[p*WIDTH +: WIDTH] = hit ? wd : regs[addr];
    assign rd_busy[p] = (addr != '0) && (cnt[addr] != '0) && !clears;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb with default
//            parameters (32x32, two read ports, forwarding on, CW=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREAD*AW-1:0]    ra;
  logic [NREAD*WIDTH-1:0] rd;
  logic [NREAD-1:0]       rd_busy;
  logic                   we;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       wd;
  logic                   iss;
  logic [AW-1:0]          iss_dst;
  logic                   iss_ready;
  logic                   flush;

  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .iss       (iss),
    .iss_dst   (iss_dst),
    .iss_ready (iss_ready),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    ra[p*AW +: AW] = a;
  endtask

  function automatic logic [WIDTH-1:0] rdp(input int p);
    return rd[p*WIDTH +: WIDTH];
  endfunction

  initial begin
    reset = 1'b1; ra = '0; we = 1'b0; wa = '0; wd = '0;
    iss = 1'b0; iss_dst = '0; flush = 1'b0;
    // Stimulus under reset must not leak into state.
    we = 1'b1; wa = 5'd2; wd = 32'h5555; iss = 1'b1; iss_dst = 5'd2;
    set_ra(0, 5'd2);
    tick(); tick();
    we = 1'b0; iss = 1'b0;
    #1;
    chk("reset_rd0", 64'(rdp(0)), 64'h0);
    chk("reset_busy", 64'(rd_busy), 64'h0);
    chk("reset_iss_ready", 64'(iss_ready), 64'h1);
    reset = 1'b0;
    tick();

    // Write r5 with forwarding, then read back after the edge.
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; set_ra(0, 5'd5);
    #1 chk("bypass_r5", 64'(rdp(0)), 64'hDEADBEEF);
    tick(); we = 1'b0;
    #1 chk("stored_r5", 64'(rdp(0)), 64'hDEADBEEF);

    // r0 ignores writes; issue to r0 is always ready and never busy.
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; set_ra(1, 5'd0);
    #1 chk("r0_before", 64'(rdp(1)), 64'h0);
    tick(); we = 1'b0;
    #1 chk("r0_after", 64'(rdp(1)), 64'h0);
    iss = 1'b1; iss_dst = 5'd0;
    #1 chk("r0_iss_ready", 64'(iss_ready), 64'h1);
    tick(); iss = 1'b0;
    #1 chk("r0_busy", 64'(rd_busy), 64'h0);

    // Saturate r7 (MAXPEND=3), then retire three times.
    set_ra(0, 5'd7); set_ra(1, 5'd7);
    iss = 1'b1; iss_dst = 5'd7;
    #1 chk("r7_ready_0", 64'(iss_ready), 64'h1);
    tick();
    #1 chk("r7_busy_1", 64'(rd_busy), 64'h3);
    tick(); tick();
    #1 chk("r7_ready_full", 64'(iss_ready), 64'h0);
    tick(); iss = 1'b0;          // fourth issue is dropped
    #1 chk("r7_ready_still_full", 64'(iss_ready), 64'h0);
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    #1 chk("r7_wb1_busy", 64'(rd_busy), 64'h3);
    tick(); wd = 32'h22;
    #1 chk("r7_wb2_busy", 64'(rd_busy), 64'h3);
    tick(); wd = 32'h33;
    #1 chk("r7_wb3_busy_clear", 64'(rd_busy), 64'h0);
    chk("r7_wb3_bypass", 64'(rdp(0)), 64'h33);
    tick(); we = 1'b0;
    #1 chk("r7_idle_busy", 64'(rd_busy), 64'h0);
    chk("r7_data_port1", 64'(rdp(1)), 64'h33);
    chk("r7_ready_after", 64'(iss_ready), 64'h1);

    // Issue and retire on r3 in the same cycle: counter holds at 1.
    iss = 1'b1; iss_dst = 5'd3; set_ra(0, 5'd3);
    tick();
    we = 1'b1; wa = 5'd3; wd = 32'hAB;
    #1 chk("r3_same_busy", 64'(rd_busy[0]), 64'h1);
    tick(); iss = 1'b0; we = 1'b0;
    #1 chk("r3_busy_held", 64'(rd_busy[0]), 64'h1);
    chk("r3_data", 64'(rdp(0)), 64'hAB);
    we = 1'b1; wd = 32'hAC;      // retires the single remaining write
    #1 chk("r3_last_retire", 64'(rd_busy[0]), 64'h0);
    tick(); we = 1'b0;
    #1 chk("r3_idle", 64'(rd_busy[0]), 64'h0);

    // cnt[4]=2, cnt[9]=1, then flush together with a write to r4.
    iss = 1'b1; iss_dst = 5'd4;
    tick(); tick();
    iss_dst = 5'd9;
    tick(); iss = 1'b0;
    set_ra(0, 5'd4); set_ra(1, 5'd9);
    #1 chk("pre_flush_busy", 64'(rd_busy), 64'h3);
    flush = 1'b1; we = 1'b1; wa = 5'd4; wd = 32'h12;
    tick(); flush = 1'b0; we = 1'b0;
    #1 chk("flush_busy", 64'(rd_busy), 64'h0);
    chk("flush_r4", 64'(rdp(0)), 64'h12);

    // Issue r4 while writing r9 (idle counter stays at 0).
    iss = 1'b1; iss_dst = 5'd4; we = 1'b1; wa = 5'd9; wd = 32'h99;
    tick(); iss = 1'b0; we = 1'b0;
    #1 chk("split_busy", 64'(rd_busy), 64'h1);
    chk("split_r9", 64'(rdp(1)), 64'h99);

    // Mid-stream reset discards data and pending writes.
    iss = 1'b1; iss_dst = 5'd10;
    tick(); iss = 1'b0;
    set_ra(0, 5'd10); set_ra(1, 5'd4);
    #1 chk("pre_reset_busy", 64'(rd_busy), 64'h3);
    reset = 1'b1;
    tick(); reset = 1'b0;
    iss_dst = 5'd4;
    #1 chk("post_reset_rd", 64'(rd), 64'h0);
    chk("post_reset_busy", 64'(rd_busy), 64'h0);
    chk("post_reset_ready", 64'(iss_ready), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
- REQ-001: Parameter WIDTH, default 32: data width of each register.
- REQ-002: Parameter NREGS, default 32: number of registers (power of 2, >= 2); address width AW = log2(NREGS).
- REQ-003: Parameter NREAD, default 2: number of independent combinational read ports (1..4).
- REQ-004: Parameter BYPASS, default 1: 1 enables write-to-read forwarding on the same cycle; 0 disables it.
- REQ-005: Parameter CW, default 2: width of the per-register pending-write counter; MAXPEND = 2^CW - 1.
- REQ-006: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-007: clk  input  1  clock; all state updates on the rising edge.
- REQ-008: reset  input  1  synchronous, active-high reset.
- REQ-009: ra  input  NREAD*AW  read addresses, port p at bits [p*AW +: AW].
- REQ-010: rd  output  NREAD*WIDTH  read data, port p at bits [p*WIDTH +: WIDTH].
- REQ-011: rd_busy  output  NREAD  1 = register addressed by port p has a pending write.
- REQ-012: we  input  1  writeback enable.
- REQ-013: wa  input  AW  writeback address.
- REQ-014: wd  input  WIDTH  writeback data.
- REQ-015: iss  input  1  issue of an instruction that will write register iss_dst.
- REQ-016: iss_dst  input  AW  destination of the issued instruction.
- REQ-017: iss_ready  output  1  0 = counter of iss_dst is at MAXPEND; issue not accepted.
- REQ-018: flush  input  1  clear all pending counters (pipeline flush).

Function
- REQ-019: On a rising edge with we=1 and wa!=0, the block SHALL load wd into register wa; register 0 SHALL always read 0 and ignore writes.
- REQ-020: rd for port p SHALL be the combinational contents of register ra[p]; latency 0.
- REQ-021: With BYPASS=1, we=1, wa!=0 and ra[p]==wa, rd for port p SHALL equal wd in the same cycle; with BYPASS=0 it SHALL show the old value until after the edge.
- REQ-022: Each register r SHALL have a CW-bit pending counter cnt[r]; cnt[0] SHALL always be 0.
- REQ-023: Issue acceptance: iss=1, iss_dst!=0 and cnt[iss_dst]<MAXPEND SHALL increment cnt[iss_dst] at the edge.
- REQ-024: iss_ready SHALL equal (iss_dst==0) or (cnt[iss_dst]<MAXPEND), computed combinationally; iss with iss_ready=0 SHALL be dropped with no state change.
- REQ-025: Writeback retirement: we=1, wa!=0 and cnt[wa]>0 SHALL decrement cnt[wa]; at cnt[wa]=0 the counter SHALL stay 0 (no underflow) while data is still written.
- REQ-026: Simultaneous accepted issue and retirement on the same register SHALL leave cnt unchanged; on different registers both SHALL apply.
- REQ-027: Simultaneous issue to a full counter and retirement of the same register SHALL decrement only (issue dropped, iss_ready=0 that cycle).
- REQ-028: rd_busy[p] SHALL be 1 when ra[p]!=0 and cnt[ra[p]]>0; with BYPASS=1, a retirement to ra[p] in the same cycle that brings cnt to 0 SHALL force rd_busy[p]=0.
- REQ-029: flush=1 SHALL clear every cnt at the edge, overriding issue and retirement counter updates; the register data write of that cycle SHALL still occur.
- REQ-030: Read ports SHALL be fully independent; identical addresses on several ports SHALL return identical data and busy.

Reset
- REQ-031: reset=1 at an edge SHALL clear all registers to 0 and all counters to 0, overriding we, iss and flush.
- REQ-032: During and after reset: rd=0 on all ports, rd_busy=0, iss_ready=1; reset in mid-operation SHALL discard all pending state.

Verification
- REQ-033: Reset, then we=1 wa=5 wd=0xDEADBEEF, ra[0]=5 -> rd[0]=0xDEADBEEF in the same cycle (BYPASS=1), and after the edge with we=0.
- REQ-034: we=1 wa=0 wd=0xFFFFFFFF, ra[1]=0 -> rd[1]=0 before and after the edge; iss iss_dst=0 -> iss_ready=1, rd_busy stays 0.
- REQ-035: Issue to r7 three times (CW=2) -> iss_ready=0 on the 4th, which is dropped; three writebacks to r7 -> rd_busy for ra=7 deasserts in the cycle of the 3rd (BYPASS=1).
- REQ-036: cnt[3]=1; iss=1 iss_dst=3 and we=1 wa=3 on the same edge -> cnt[3] stays 1, r3 updated, rd_busy=1.
- REQ-037: cnt[4]=2, cnt[9]=1; flush=1 with we=1 wa=4 wd=0x12 -> all counters 0, r4=0x12.
- REQ-038: Mid-stream reset with pending counters and nonzero registers -> next cycle all rd=0, rd_busy=0, iss_ready=1.
